// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one byte-wide memory port between a CPU requester and a DMA/loader
//   requester. Each granted access holds the memory strobe for WAIT_CYCLES
//   cycles, then pulses the winner's ack for one cycle with read data.
//   A requester may lock the bus so its next access cannot be split from the
//   current one. DMA starvation is bounded by STARVE_LIMIT consecutive CPU grants.
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   cpu_req/we/lock/addr/wdata CPU request, fields stable until cpu_ack
//   cpu_rdata, cpu_ack         CPU read data (held between reads), completion pulse
//   dma_*                      DMA equivalents of the CPU ports
//   mem_addr/wdata/read/write  memory port, driven from the latched request
//   mem_rdata                  memory read data, sampled in the last strobe cycle
//   owner                      00 none, 01 CPU, 10 DMA
module mem_bus_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int WAIT_CYCLES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_lock,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_CPU   = 2'b01;
  localparam logic [1:0] OWN_DMA   = 2'b10;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);

  state_t     state;
  req_t       cpu_r, dma_r, win_r, lat;
  logic [3:0] wait_cnt;
  logic [3:0] starve_cnt;
  logic       lock_held;
  logic       cur_dma;      // current access belongs to DMA
  logic       grant_cpu, grant_dma;

  always_comb begin
    cpu_r = '{we: cpu_we, lock: cpu_lock, addr: cpu_addr, wdata: cpu_wdata};
    dma_r = '{we: dma_we, lock: dma_lock, addr: dma_addr, wdata: dma_wdata};
  end

  // While locked, owner still names the lock holder, so it selects who may go.
  always_comb begin
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    if (lock_held) begin
      grant_cpu = (owner == OWN_CPU) && cpu_req;
      grant_dma = (owner == OWN_DMA) && dma_req;
    end else if (dma_req && (!cpu_req || starve_cnt == LIMIT)) begin
      grant_dma = 1'b1;
    end else begin
      grant_cpu = cpu_req;
    end
    win_r = grant_dma ? dma_r : cpu_r;
  end

  assign mem_addr  = lat.addr;
  assign mem_wdata = lat.wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lat        <= '0;
      cur_dma    <= 1'b0;
      lock_held  <= 1'b0;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
      owner      <= OWN_NONE;
    end else begin
      unique case (state)
        IDLE: begin
          // Counts CPU grants that made a waiting DMA wait; saturates at the limit.
          if (grant_dma || !dma_req) starve_cnt <= '0;
          else if (grant_cpu && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
          if (grant_cpu || grant_dma) begin
            lat       <= win_r;
            cur_dma   <= grant_dma;
            owner     <= grant_dma ? OWN_DMA : OWN_CPU;
            mem_read  <= ~win_r.we;
            mem_write <= win_r.we;
            wait_cnt  <= WAIT_LAST;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (wait_cnt == '0) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (!lat.we) begin
              if (cur_dma) dma_rdata <= mem_rdata;
              else         cpu_rdata <= mem_rdata;
            end
            cpu_ack <= ~cur_dma;
            dma_ack <= cur_dma;
            state   <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          cpu_ack   <= 1'b0;
          dma_ack   <= 1'b0;
          // The lock bit of the access just finished decides whether the bus stays held.
          lock_held <= lat.lock;
          if (!lat.lock) owner <= OWN_NONE;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
